fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Configuration controller for the programmable 4-tap FIR datapath. Accepts a byte-wide
//  command stream and writes coefficients into a shadow bank. Swaps the shadow bank into the
//  active bank atomically on a sample boundary, so the FIR core never sees a mixed set.
//  Sits between the uio pins (config port) and the fir_core coefficient inputs in tt_um_fir_filter.
// PARAMETERS
//  NTAPS      4      number of FIR taps / coefficient registers (1..8)
//  CW         8      coefficient width, bits (= cfg byte width, fixed 8)
//  RST_TAP0   8'h01  reset value of tap 0 (shadow and active); all other taps reset to 0 (passthrough)
// PORTS
//  clk            in   1         system clock; all logic rising-edge
//  rst_n          in   1         asynchronous, active-low reset
//  cfg_data       in   8         command/data byte
//  cfg_valid      in   1         cfg_data valid this cycle
//  cfg_ready      out  1         loader can accept a byte this cycle
//  sample_strobe  in   1         1-cycle pulse when the delay line shifts in a new sample
//  coef_active    out  NTAPS*CW  active coefficients to FIR core; tap i = [i*CW +: CW]
//  commit_pending out  1         COMMIT accepted, waiting for sample_strobe
//  commit_done    out  1         1-cycle pulse the cycle after active bank updates
//  rd_data        out  8         readback byte (shadow bank)
//  rd_valid       out  1         1-cycle pulse, rd_data valid
//  err            out  1         sticky: tap index >= NTAPS addressed; cleared only by reset
// BEHAVIOUR
//  Reset (async): state=S_CMD; shadow=active={0..,RST_TAP0}; cfg_ready=1; commit_pending=0;
//   commit_done=0; rd_data=0; rd_valid=0; err=0. Reset mid-sequence discards partial WRITE/COMMIT.
//  Transfer = cfg_valid & cfg_ready at rising edge. cfg_ready=1 in S_CMD/S_DATA, 0 in S_WAIT.
//  Command byte: [7:6] opcode, [5:3] reserved (ignored), [2:0] tap index idx.
//   00 NOP: no effect, stay S_CMD.
//   01 WRITE: latch idx -> S_DATA; next transferred byte written to shadow[idx] -> S_CMD.
//   10 COMMIT: -> S_WAIT, commit_pending=1 from next cycle.
//   11 READ: rd_data<=shadow[idx], rd_valid=1 on the following cycle only; stay S_CMD.
//  idx >= NTAPS (WRITE or READ): err<=1; WRITE still consumes its data byte, shadow unchanged;
//   READ returns rd_data=8'h00 with rd_valid pulse.
//  S_WAIT: on first sample_strobe strictly after the COMMIT-accept cycle: all NTAPS taps
//   active<=shadow in one edge; commit_pending<=0; commit_done=1 next cycle; -> S_CMD.
//   A strobe coincident with COMMIT acceptance does NOT commit.
//  coef_active changes only at a commit edge; shadow writes never alter coef_active.
//  Latency: WRITE cmd+data = 2 transfers; READ cmd -> rd_valid 1 cycle; COMMIT -> active
//   update at first qualifying strobe, commit_done 1 cycle later.
//  Back-to-back transfers allowed every cycle; cfg_valid while cfg_ready=0 is held off (no drop).
//  Unsigned/two's-complement interpretation belongs to fir_core; loader is width-transparent.
// STRUCTURE
//  Shared package fir_cfg_pkg: opcode localparams (OP_NOP/OP_WRITE/OP_COMMIT/OP_READ),
//   field positions (OPC_MSB=7, IDX_LSB=0, IDX_W=3), state encoding S_CMD/S_DATA/S_WAIT.
//  Sub-module fir_coef_bank: shadow + active register arrays, write port, read mux, commit input.
//  Top: command decoder + 3-state FSM + err/rd_valid/commit_done flops.
// TESTING
//  1 Reset: assert rst_n=0 mid-WRITE -> coef_active=32'h0000_0001, cfg_ready=1, err=0, state S_CMD.
//  2 WRITE 8'h41,8'h7F; WRITE 8'h43,8'h80; READ 8'hC1 -> rd_valid 1 cycle, rd_data=8'h7F;
//    coef_active still 32'h0000_0001.
//  3 COMMIT 8'h80, strobe 5 cycles later -> cfg_ready=0, commit_pending=1 until strobe;
//    coef_active=32'h8000_7F01 on strobe edge; commit_done pulses next cycle.
//  4 COMMIT accepted in same cycle as sample_strobe -> no update; update on next strobe.
//  5 WRITE 8'h45 (idx 5),8'hAA -> err=1, shadow/active unchanged; READ 8'hC5 -> rd_data=8'h00.
//  6 Continuous cfg_valid stream incl. NOP 8'h00 and cmd during S_WAIT -> byte held, no loss.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// Purpose: shared field positions, opcodes and FSM encoding for the FIR coefficient loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fir_cfg_pkg;

  // Command byte layout: [7:6] opcode, [5:3] reserved, [2:0] tap index
  localparam int CFG_W   = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int IDX_LSB = 0;
  localparam int IDX_W   = 3;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_DATA = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // True when a 3-bit tap index addresses an implemented tap
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int ntaps);
    return ({{(32-IDX_W){1'b0}}, idx} < ntaps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Purpose: shadow + active coefficient registers; shadow is written byte-wise, active loads all taps at once.
// Latency: write lands in shadow 1 edge after wr_en; commit copies shadow->active in 1 edge; read mux is combinational.
// Backpressure: none; the caller qualifies wr_en/commit.
module fir_coef_bank
  import fir_cfg_pkg::*;
#(
  parameter int              NTAPS    = 4,
  parameter int              CW       = 8,
  parameter logic [CW-1:0]   RST_TAP0 = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [CW-1:0]         wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [CW-1:0]         rd_mux,
  input  logic                  commit,
  output logic [NTAPS*CW-1:0]   coef_active
);

  logic [CW-1:0] shadow [NTAPS];
  logic [CW-1:0] active [NTAPS];

  // Shadow bank: byte writes from the config port; out-of-range indices match no tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) shadow[i] <= '0;
      shadow[0] <= RST_TAP0;
    end else if (wr_en) begin
      for (int i = 0; i < NTAPS; i++) begin
        if (wr_idx == IDX_W'(i)) shadow[i] <= wr_data;
      end
    end
  end

  // Active bank: every tap loads in the same edge so the FIR never sees a mixed set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) active[i] <= '0;
      active[0] <= RST_TAP0;
    end else if (commit) begin
      for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
    end
  end

  // Readback mux over the shadow bank; unimplemented taps read as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_mux = shadow[i];
    end
  end

  // Flatten the active bank: tap i occupies [i*CW +: CW]
  always_comb begin
    coef_active = '0;
    for (int i = 0; i < NTAPS; i++) coef_active[i*CW +: CW] = active[i];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Purpose: byte-stream command decoder that loads FIR coefficients into a shadow bank and commits on a sample boundary.
// Latency: WRITE = 2 transfers; READ -> rd_valid next cycle; COMMIT -> active at first later sample_strobe, commit_done 1 cycle after.
// Backpressure: cfg_ready low while a commit waits for sample_strobe; the presented byte is held, never dropped.
module fir_coeff_loader
  import fir_cfg_pkg::*;
#(
  parameter int            NTAPS    = 4,
  parameter int            CW       = 8,
  parameter logic [CW-1:0] RST_TAP0 = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CFG_W-1:0]      cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  sample_strobe,
  output logic [NTAPS*CW-1:0]   coef_active,
  output logic                  commit_pending,
  output logic                  commit_done,
  output logic [CFG_W-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  err
);

  state_t             state, state_nxt;
  logic               xfer;
  logic               cmd_xfer;
  logic [1:0]         opc;
  logic [IDX_W-1:0]   idx;
  logic               idx_ok;
  logic [IDX_W-1:0]   widx;
  logic               widx_ok;
  logic               bank_we;
  logic               commit;
  logic [CW-1:0]      bank_rd;
  logic               unused_rsvd;

  assign opc         = cfg_data[OPC_MSB:OPC_LSB];
  assign idx         = cfg_data[IDX_LSB +: IDX_W];
  assign idx_ok      = idx_in_range(idx, NTAPS);
  assign xfer        = cfg_valid & cfg_ready;
  assign cmd_xfer    = xfer && (state == S_CMD);
  assign unused_rsvd = ^cfg_data[5:3];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CMD;
    else        state <= state_nxt;
  end

  // Next-state: WRITE takes one data byte, COMMIT parks until a later strobe
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CMD: begin
        if (xfer) begin
          if (opc == OP_WRITE)       state_nxt = S_DATA;
          else if (opc == OP_COMMIT) state_nxt = S_WAIT;
        end
      end
      S_DATA: if (xfer)          state_nxt = S_CMD;
      S_WAIT: if (sample_strobe) state_nxt = S_CMD;
      default:                   state_nxt = S_CMD;
    endcase
  end

  // FSM outputs; a strobe in the COMMIT-accept cycle is still in S_CMD and so cannot commit
  always_comb begin
    cfg_ready      = 1'b1;
    commit_pending = 1'b0;
    bank_we        = 1'b0;
    commit         = 1'b0;
    case (state)
      S_DATA: bank_we = xfer && widx_ok;
      S_WAIT: begin
        cfg_ready      = 1'b0;
        commit_pending = 1'b1;
        commit         = sample_strobe;
      end
      default: ;
    endcase
  end

  // Latch the WRITE target so the following byte knows where to land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx    <= '0;
      widx_ok <= 1'b0;
    end else if (cmd_xfer && opc == OP_WRITE) begin
      widx    <= idx;
      widx_ok <= idx_ok;
    end
  end

  // Readback pulse and data; out-of-range taps read zero from the bank mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= cmd_xfer && (opc == OP_READ);
      if (cmd_xfer && opc == OP_READ) rd_data <= bank_rd;
    end
  end

  // Sticky error on any WRITE/READ addressing an unimplemented tap; commit_done follows the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err         <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      if (cmd_xfer && (opc == OP_WRITE || opc == OP_READ) && !idx_ok) err <= 1'b1;
      commit_done <= commit;
    end
  end

  fir_coef_bank #(
    .NTAPS    (NTAPS),
    .CW       (CW),
    .RST_TAP0 (RST_TAP0)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bank_we),
    .wr_idx      (widx),
    .wr_data     (cfg_data),
    .rd_idx      (idx),
    .rd_mux      (bank_rd),
    .commit      (commit),
    .coef_active (coef_active)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Purpose: directed self-checking bench for fir_coeff_loader.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: byte sender waits on cfg_ready with a bounded budget.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        sample_strobe;
  logic [31:0] coef_active;
  logic        commit_pending;
  logic        commit_done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .sample_strobe  (sample_strobe),
    .coef_active    (coef_active),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .err            (err)
  );

  // Present one byte at a falling edge, wait (bounded) for acceptance, return at the next falling edge
  task automatic send(input logic [7:0] b);
    int n;
    cfg_data  = b;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_accept: cfg_ready=%b required 1 for byte %h", cfg_ready, b);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if (coef_active !== 32'h0000_0001 || cfg_ready !== 1'b1 || commit_pending !== 1'b0 ||
        commit_done !== 1'b0 || rd_data !== 8'h00 || rd_valid !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: coef=%h rdy=%b pend=%b done=%b rd=%h rdv=%b err=%b required 00000001 1 0 0 00 0 0",
               coef_active, cfg_ready, commit_pending, commit_done, rd_data, rd_valid, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h42);
    send(8'h55);
    send(8'h41);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (coef_active !== 32'h0000_0001 || cfg_ready !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midwrite: coef=%h rdy=%b err=%b required 00000001 1 0", coef_active, cfg_ready, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hC2);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_shadow_tap2: rdv=%b rd=%h required 1 00", rd_valid, rd_data);
    end
    send(8'hC0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL reset_shadow_tap0: rdv=%b rd=%h required 1 01", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read;
    send(8'h41); send(8'h7F);
    send(8'h43); send(8'h80);
    send(8'hC1);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h7F) begin
      tests_failed++;
      $display("FAIL read_tap1: rdv=%b rd=%h required 1 7f", rd_valid, rd_data);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0 || coef_active !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL read_pulse_shadow_iso: rdv=%b coef=%h required 0 00000001", rd_valid, coef_active);
    end
    send(8'hC3);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h80) begin
      tests_failed++;
      $display("FAIL read_tap3: rdv=%b rd=%h required 1 80", rd_valid, rd_data);
    end
  endtask

  task automatic test_commit;
    send(8'h80);
    tests_run++;
    if (cfg_ready !== 1'b0 || commit_pending !== 1'b1 || coef_active !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL commit_wait: rdy=%b pend=%b coef=%h required 0 1 00000001", cfg_ready, commit_pending, coef_active);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (cfg_ready !== 1'b0 || commit_pending !== 1'b1 || coef_active !== 32'h0000_0001 || commit_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_hold: rdy=%b pend=%b coef=%h done=%b required 0 1 00000001 0",
               cfg_ready, commit_pending, coef_active, commit_done);
    end
    sample_strobe = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (coef_active !== 32'h8000_7F01) begin
      tests_failed++;
      $display("FAIL commit_edge: coef=%h required 80007f01", coef_active);
    end
    @(negedge clk);
    sample_strobe = 1'b0;
    tests_run++;
    if (commit_done !== 1'b1 || commit_pending !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL commit_done_pulse: done=%b pend=%b rdy=%b required 1 0 1", commit_done, commit_pending, cfg_ready);
    end
    @(negedge clk);
    tests_run++;
    if (commit_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_done_width: done=%b required 0", commit_done);
    end
  endtask

  task automatic test_commit_coincident;
    send(8'h40); send(8'h22);
    cfg_data      = 8'h80;
    cfg_valid     = 1'b1;
    sample_strobe = 1'b1;
    @(negedge clk);
    cfg_valid     = 1'b0;
    sample_strobe = 1'b0;
    tests_run++;
    if (coef_active !== 32'h8000_7F01 || commit_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL coincident_no_commit: coef=%h pend=%b required 80007f01 1", coef_active, commit_pending);
    end
    @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    tests_run++;
    if (coef_active !== 32'h8000_7F22 || commit_done !== 1'b1 || commit_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL coincident_next_strobe: coef=%h done=%b pend=%b required 80007f22 1 0",
               coef_active, commit_done, commit_pending);
    end
  endtask

  task automatic test_bad_index;
    send(8'h45);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_write_err: err=%b required 1", err);
    end
    send(8'hAA);
    tests_run++;
    if (cfg_ready !== 1'b1 || commit_pending !== 1'b0 || coef_active !== 32'h8000_7F22) begin
      tests_failed++;
      $display("FAIL bad_write_data_consumed: rdy=%b pend=%b coef=%h required 1 0 80007f22",
               cfg_ready, commit_pending, coef_active);
    end
    send(8'hC5);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_read: rdv=%b rd=%h err=%b required 1 00 1", rd_valid, rd_data, err);
    end
    send(8'hC1);
    tests_run++;
    if (rd_data !== 8'h7F) begin
      tests_failed++;
      $display("FAIL bad_write_shadow_iso: rd=%h required 7f", rd_data);
    end
  endtask

  task automatic test_back_to_back;
    send(8'h00);
    send(8'h42);
    send(8'h33);
    send(8'h80);
    cfg_data  = 8'hC2;
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (cfg_ready !== 1'b0 || rd_valid !== 1'b0 || commit_pending !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_off_%0d: rdy=%b rdv=%b pend=%b required 0 0 1", i, cfg_ready, rd_valid, commit_pending);
      end
      @(negedge clk);
    end
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    tests_run++;
    if (coef_active !== 32'h8033_7F22 || commit_done !== 1'b1 || cfg_ready !== 1'b1 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_commit: coef=%h done=%b rdy=%b rdv=%b required 80337f22 1 1 0",
               coef_active, commit_done, cfg_ready, rd_valid);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h33) begin
      tests_failed++;
      $display("FAIL held_byte_delivered: rdv=%b rd=%h required 1 33", rd_valid, rd_data);
    end
    send(8'h00);
    tests_run++;
    if (rd_valid !== 1'b0 || coef_active !== 32'h8033_7F22 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL nop_no_effect: rdv=%b coef=%h err=%b required 0 80337f22 1", rd_valid, coef_active, err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cfg_data      = 8'h00;
    cfg_valid     = 1'b0;
    sample_strobe = 1'b0;
    test_reset;
    test_write_read;
    test_commit;
    test_commit_coincident;
    test_bad_index;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
